imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time instruction loader placed directly upstream of the single-cycle core's instruction memory write port.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into imem at sequential word addresses.
- Holds the core in reset until the programmed word count has been written, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; word aligned.
- MAX_WORDS, 1024, largest legal load length in words.
- CNT_W, 11, width of the word counter and of len_i; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start_i  input  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- len_i  input  CNT_W  number of words to load; latched on the accepted start_i.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader can accept a byte.
- wr_en_imem_o  output  1  one-cycle imem write strobe.
- wr_addr_imem_o  output  32  imem byte address for the write.
- wr_instr_imem_o  output  32  instruction word to write.
- cpu_hold_o  output  1  1 = core held in reset.
- busy_o  output  1  load in progress.
- done_o  output  1  load completed successfully; sticky until the next accepted start_i.
- err_o  output  1  load rejected or failed; sticky until the next accepted start_i.

Behaviour:
- Reset values:
  - State IDLE.
  - byte_ready_o=0, wr_en_imem_o=0, wr_addr_imem_o=0, wr_instr_imem_o=0.
  - cpu_hold_o=1, busy_o=0, done_o=0, err_o=0.
  - Word counter, byte counter and length register all 0.
- States: IDLE, RECV, WRITE, DONE (plus CSUM when the optional feature is compiled in).
- IDLE and DONE, on start_i:
  - Clears done_o and err_o, latches len_i, zeroes both counters.
  - len_i==0: go to DONE; done_o=1 next cycle; no writes.
  - len_i>MAX_WORDS: err_o=1; stay in (or return to) IDLE; cpu_hold_o=1.
  - Otherwise: go to RECV; busy_o=1; cpu_hold_o=1.
- RECV:
  - byte_ready_o=1.
  - A byte transfers on a cycle where byte_valid_i && byte_ready_o.
  - Byte k (k=0..3) is stored to word bits [8k+7:8k].
  - The cycle the 4th byte is accepted: move to WRITE.
- WRITE:
  - Lasts exactly one cycle; byte_ready_o=0.
  - wr_en_imem_o=1, wr_addr_imem_o=BASE_ADDR+{word_cnt,2'b00}, wr_instr_imem_o=assembled word.
  - word_cnt increments and the byte counter clears.
  - word_cnt+1==len: go to DONE; otherwise back to RECV.
- DONE:
  - busy_o=0, done_o=1, cpu_hold_o=0.
  - The core starts from its own reset PC on the first cycle cpu_hold_o is 0.
- Throughput: 5 cycles per word at best (4 accepted bytes, then 1 write cycle).
- start_i while busy (RECV/WRITE/CSUM) is ignored.
- byte_valid_i while byte_ready_o=0 is not consumed; the source must hold the byte.
- Address wraps modulo 2^32; this is unreachable for legal MAX_WORDS.
- Reset asserted mid-load aborts immediately to the reset values. imem contents written so far are not cleared.

Optional Feature:
- Macro IMEM_LOADER_CSUM_EN.
- With the macro defined:
  - After the last WRITE, the loader enters CSUM and accepts 4 more bytes, little-endian, as the expected checksum.
  - The checksum is the 32-bit sum, modulo 2^32, of all written words.
  - Match: go to DONE.
  - Mismatch: err_o=1, done_o=0, cpu_hold_o stays 1, return to IDLE.
  - len_i==0 still goes to DONE directly, with no checksum bytes.
- Without the macro: no CSUM state and no accumulator; DONE follows the last WRITE.

Test Plan:
- Reset low for 3 cycles, then high -> cpu_hold_o=1, byte_ready_o=0, done_o=0, err_o=0, state IDLE.
- start_i with len_i=2; bytes 13,00,08,20 then 04,00,09,21 sent back-to-back -> writes 0x20080013 @0x0 and 0x21090004 @0x4, one-cycle strobes 5 cycles apart; done_o=1 and cpu_hold_o=0 after the 2nd write.
- Same load with byte_valid_i toggling every other cycle and a stray start_i mid-load -> identical writes; start_i has no effect.
- start_i with len_i=MAX_WORDS+1 -> err_o=1, no wr_en_imem_o, cpu_hold_o=1; then start_i with len_i=0 -> err_o cleared, done_o=1, no writes.
- Reset driven low after the 2nd byte of word 1 of a 3-word load -> all outputs return to reset values within the same cycle; a fresh len_i=1 load then completes normally.
- IMEM_LOADER_CSUM_EN, len_i=2 with the words above: checksum bytes 17,00,11,41 (0x41110017) -> done_o=1; checksum 0x41110018 -> err_o=1, cpu_hold_o=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time imem loader: assembles little-endian words from a byte stream and holds the core in reset until loaded.
// Optional checksum trailer check is compiled in with IMEM_LOADER_CSUM_EN.
//
// state | meaning
// IDLE  | waiting for start_i (after reset or a rejected/failed load)
// RECV  | collecting the 4 bytes of the current word
// WRITE | one-cycle imem write strobe for the assembled word
// DONE  | load complete, core released
// CSUM  | collecting the 4-byte expected checksum (IMEM_LOADER_CSUM_EN only)
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024,
   parameter int          CNT_W     = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_data_i,
   output logic             byte_ready_o,
   output logic             wr_en_imem_o,
   output logic [31:0]      wr_addr_imem_o,
   output logic [31:0]      wr_instr_imem_o,
   output logic             cpu_hold_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
`ifdef IMEM_LOADER_CSUM_EN
      , CSUM
`endif
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] len_q;
   logic [1:0]       byte_cnt;
   logic [23:0]      word_buf;
   logic             byte_fire;
   logic [31:0]      word_full;
`ifdef IMEM_LOADER_CSUM_EN
   logic [31:0]      csum;
`endif

   // Earlier bytes are shifted down, so after three bytes word_buf holds {b2,b1,b0}.
   assign byte_fire = byte_valid_i & byte_ready_o;
   assign word_full = {byte_data_i, word_buf};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         word_cnt        <= '0;
         len_q           <= '0;
         byte_cnt        <= '0;
         word_buf        <= '0;
         byte_ready_o    <= 1'b0;
         wr_en_imem_o    <= 1'b0;
         wr_addr_imem_o  <= '0;
         wr_instr_imem_o <= '0;
         cpu_hold_o      <= 1'b1;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         err_o           <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         csum            <= '0;
`endif
      end else begin
         wr_en_imem_o <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  done_o   <= 1'b0;
                  err_o    <= 1'b0;
                  len_q    <= len_i;
                  word_cnt <= '0;
                  byte_cnt <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                  csum     <= '0;
`endif
                  if (len_i == '0) begin
                     state        <= DONE;
                     done_o       <= 1'b1;
                     cpu_hold_o   <= 1'b0;
                     busy_o       <= 1'b0;
                     byte_ready_o <= 1'b0;
                  end else if (len_i > MAX_LEN) begin
                     state        <= IDLE;
                     err_o        <= 1'b1;
                     cpu_hold_o   <= 1'b1;
                     busy_o       <= 1'b0;
                     byte_ready_o <= 1'b0;
                  end else begin
                     state        <= RECV;
                     cpu_hold_o   <= 1'b1;
                     busy_o       <= 1'b1;
                     byte_ready_o <= 1'b1;
                  end
               end
            end

            RECV: begin
               if (byte_fire) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  word_buf <= {byte_data_i, word_buf[23:8]};
                  if (byte_cnt == 2'd3) begin
                     state           <= WRITE;
                     byte_ready_o    <= 1'b0;
                     wr_en_imem_o    <= 1'b1;
                     wr_addr_imem_o  <= BASE_ADDR + (32'(word_cnt) << 2);
                     wr_instr_imem_o <= word_full;
`ifdef IMEM_LOADER_CSUM_EN
                     csum            <= csum + word_full;
`endif
                  end
               end
            end

            WRITE: begin
               word_cnt <= word_cnt + CNT_W'(1);
               byte_cnt <= '0;
               if (word_cnt + CNT_W'(1) == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                  state        <= CSUM;
                  byte_ready_o <= 1'b1;
`else
                  state        <= DONE;
                  busy_o       <= 1'b0;
                  done_o       <= 1'b1;
                  cpu_hold_o   <= 1'b0;
`endif
               end else begin
                  state        <= RECV;
                  byte_ready_o <= 1'b1;
               end
            end

`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
               if (byte_fire) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  word_buf <= {byte_data_i, word_buf[23:8]};
                  if (byte_cnt == 2'd3) begin
                     byte_ready_o <= 1'b0;
                     busy_o       <= 1'b0;
                     if (word_full == csum) begin
                        state      <= DONE;
                        done_o     <= 1'b1;
                        cpu_hold_o <= 1'b0;
                     end else begin
                        state      <= IDLE;
                        err_o      <= 1'b1;
                        cpu_hold_o <= 1'b1;
                     end
                  end
               end
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed cases plus random loads against a word-level reference model.
module tb_imem_loader;

   localparam int MAX_WORDS = 1024;
   localparam int CNT_W     = 11;
`ifdef IMEM_LOADER_CSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             start_i;
   logic [CNT_W-1:0] len_i;
   logic             byte_valid_i;
   logic [7:0]       byte_data_i;
   logic             byte_ready_o;
   logic             wr_en_imem_o;
   logic [31:0]      wr_addr_imem_o;
   logic [31:0]      wr_instr_imem_o;
   logic             cpu_hold_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;

   imem_loader #(
      .BASE_ADDR (32'h0000_0000),
      .MAX_WORDS (MAX_WORDS),
      .CNT_W     (CNT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start_i),
      .len_i           (len_i),
      .byte_valid_i    (byte_valid_i),
      .byte_data_i     (byte_data_i),
      .byte_ready_o    (byte_ready_o),
      .wr_en_imem_o    (wr_en_imem_o),
      .wr_addr_imem_o  (wr_addr_imem_o),
      .wr_instr_imem_o (wr_instr_imem_o),
      .cpu_hold_o      (cpu_hold_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_o           (err_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // write monitor, sampled on the falling edge
   logic [31:0] got_a[$];
   logic [31:0] got_d[$];
   int          got_t[$];
   int          cyc       = 0;
   int          dbl       = 0;
   int          done_rise = -1;
   logic        wr_prev   = 1'b0;
   logic        done_prev = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (wr_en_imem_o) begin
         got_a.push_back(wr_addr_imem_o);
         got_d.push_back(wr_instr_imem_o);
         got_t.push_back(cyc);
         if (wr_prev) dbl++;
      end
      if (done_o && !done_prev) done_rise = cyc;
      wr_prev   = wr_en_imem_o;
      done_prev = done_o;
   end

   logic [7:0] stim[$];

   task automatic fill_rand(input int n);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hold"},  cpu_hold_o, 1);
      chk({tag, "_ready"}, byte_ready_o, 0);
      chk({tag, "_busy"},  busy_o, 0);
      chk({tag, "_done"},  done_o, 0);
      chk({tag, "_err"},   err_o, 0);
      chk({tag, "_wren"},  wr_en_imem_o, 0);
      chk({tag, "_addr"},  wr_addr_imem_o, 0);
      chk({tag, "_instr"}, wr_instr_imem_o, 0);
   endtask

   // mode 0: valid always high, 1: valid every other cycle, 2: random valid
   task automatic run_load(input int len, input int mode, input bit stray, input bit bad_csum, input string tag);
      logic [7:0]  bq[$];
      logic [31:0] exp_a[$];
      logic [31:0] exp_d[$];
      logic [31:0] wd;
      logic [31:0] sum;
      int          idx;
      int          budget;
      bit          rdy;
      bit          vld;
      bit          exp_ok;
      sum = 32'h0;
      for (int w = 0; w < len; w++) begin
         wd = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
         exp_a.push_back(32'(4 * w));
         exp_d.push_back(wd);
         sum = sum + wd;
         for (int b = 0; b < 4; b++) bq.push_back(stim[4*w+b]);
      end
      if (CSUM_ON && len > 0) begin
         if (bad_csum) sum = sum + 32'h1;
         for (int b = 0; b < 4; b++) bq.push_back(sum[8*b +: 8]);
      end
      exp_ok = !(CSUM_ON && len > 0 && bad_csum);

      got_a.delete(); got_d.delete(); got_t.delete();
      @(negedge clk);
      start_i = 1'b1;
      len_i   = CNT_W'(len);
      @(negedge clk);
      start_i = 1'b0;

      idx = 0;
      budget = 0;
      while (idx < bq.size() && budget < 40 * bq.size() + 20) begin
         rdy = byte_ready_o;
         case (mode)
            0:       vld = 1'b1;
            1:       vld = budget[0];
            default: vld = ($urandom_range(0, 2) != 0);
         endcase
         byte_valid_i = vld;
         byte_data_i  = vld ? bq[idx] : 8'($urandom);
         if (stray && budget == 7) begin
            start_i = 1'b1;
            len_i   = '0;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk);
         if (vld && rdy) idx++;
         budget++;
      end
      byte_valid_i = 1'b0;
      start_i      = 1'b0;
      chk({tag, "_feed"}, idx, bq.size());

      for (int i = 0; i < 20 && !(done_o || err_o); i++) @(negedge clk);
      chk({tag, "_finished"}, done_o || err_o, 1);
      repeat (2) @(negedge clk);

      chk({tag, "_nwr"}, got_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), got_a[i], exp_a[i]);
         chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      end
      chk({tag, "_done"}, done_o, exp_ok);
      chk({tag, "_err"},  err_o, !exp_ok);
      chk({tag, "_hold"}, cpu_hold_o, !exp_ok);
      chk({tag, "_busy"}, busy_o, 0);
   endtask

   task automatic load_demo_words();
      stim.delete();
      stim = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00, 8'h09, 8'h21};
   endtask

   initial begin
      int acc;
      int bud;
      reset        = 1'b0;
      start_i      = 1'b0;
      len_i        = '0;
      byte_valid_i = 1'b0;
      byte_data_i  = 8'h00;

      repeat (3) @(negedge clk);
      chk_reset_vals("rst_in");
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst_out");

      // back-to-back two-word load
      load_demo_words();
      run_load(2, 0, 1'b0, 1'b0, "b2b");
      if (got_t.size() == 2) begin
         chk("b2b_gap", got_t[1] - got_t[0], 5);
         if (!CSUM_ON) chk("b2b_done_lat", done_rise, got_t[1] + 1);
      end
      chk("b2b_strobe_width", dbl, 0);

      // throttled source and a stray start while busy
      load_demo_words();
      run_load(2, 1, 1'b1, 1'b0, "toggle");

      // oversized length is rejected, then an empty load completes
      @(negedge clk);
      got_a.delete();
      start_i = 1'b1;
      len_i   = CNT_W'(MAX_WORDS + 1);
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("big_err",  err_o, 1);
      chk("big_hold", cpu_hold_o, 1);
      chk("big_done", done_o, 0);
      chk("big_busy", busy_o, 0);
      chk("big_ready", byte_ready_o, 0);
      chk("big_nwr",  got_a.size(), 0);
      run_load(0, 0, 1'b0, 1'b0, "zero");

      // reset mid-load after the 2nd byte of word 1
      fill_rand(12);
      @(negedge clk);
      start_i = 1'b1;
      len_i   = CNT_W'(3);
      @(negedge clk);
      start_i = 1'b0;
      acc = 0;
      bud = 0;
      while (acc < 6 && bud < 100) begin
         byte_valid_i = 1'b1;
         byte_data_i  = stim[acc];
         if (byte_ready_o) begin
            @(negedge clk);
            acc++;
         end else begin
            @(negedge clk);
         end
         bud++;
      end
      byte_valid_i = 1'b0;
      chk("mid_feed", acc, 6);
      chk("mid_busy_before", busy_o, 1);
      reset = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      fill_rand(4);
      run_load(1, 0, 1'b0, 1'b0, "after_rst");

      // random loads checked against the word model
      for (int it = 0; it < 6; it++) begin
         int  len;
         bit  bad;
         len = $urandom_range(1, 5);
         bad = CSUM_ON && ($urandom_range(0, 1) == 1);
         fill_rand(4 * len);
         run_load(len, 2, ($urandom_range(0, 1) == 1), bad, $sformatf("rnd%0d", it));
      end

      if (CSUM_ON) begin
         load_demo_words();
         run_load(2, 0, 1'b0, 1'b0, "csum_good");
         load_demo_words();
         run_load(2, 0, 1'b0, 1'b1, "csum_bad");
      end

      chk("strobe_width_all", dbl, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, got %0d cycles expected fewer", cyc);
      $fatal(1, "timeout");
   end

endmodule
